// File: rtl/mips_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// opcodes, ALU and mux selects, and FSM states.
package mips_defs_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECUTE, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ERROR
   } state_t;

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Counts consecutive memory-stall cycles and flags when
// the stall budget is used up; MAX of 0 disables it.
module multicycle_control_wait_timer #(
   parameter int MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   output logic expire
);

   generate
      if (MAX > 0) begin : g_on
         localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
         logic [W-1:0] cnt;

         assign expire = busy && (cnt == W'(MAX));

         always_ff @(posedge clk) begin
            if (rst || !busy || expire)
               cnt <= '0;
            else
               cnt <= cnt + W'(1);
         end
      end else begin : g_off
         logic unused;
         assign unused = &{1'b0, clk, rst, busy};
         assign expire = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath with
// a memory-ready handshake, stall timeout and retire counter.
import mips_defs_pkg::*;

module multicycle_control #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwrite_eq,
   output logic             pcwrite_ne,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regdst,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsource,
   output logic             illegal,
   output logic             error,
   output logic [CNT_W-1:0] instr_count
);

   state_t     state;
   state_t     next;
   logic [5:0] op_q;
   logic       retire;
   logic       in_wait;
   logic       expire;

   assign in_wait = (state == FETCH) || (state == MEMRD) ||
                    (state == MEMWR);

   multicycle_control_wait_timer #(
      .MAX(WAIT_MAX)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .busy  (in_wait && !mem_ready),
      .expire(expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= '0;
         instr_count <= '0;
      end else begin
         state <= next;
         if (state == DECODE)
            op_q <= opcode;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      next       = state;
      retire     = 1'b0;
      pcwrite    = 1'b0;
      pcwrite_eq = 1'b0;
      pcwrite_ne = 1'b0;
      iord       = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_B;
      aluop      = ALU_ADD;
      pcsource   = PC_ALU;
      illegal    = 1'b0;
      error      = 1'b0;
      unique case (state)
         IDLE: next = FETCH;
         FETCH: begin
            memread = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            if (mem_ready)
               next = DECODE;
            else if (expire)
               next = ERROR;
         end
         DECODE: begin
            alusrcb = SRCB_IMMSH;
            unique case (1'b1)
               (opcode == OP_LW),
               (opcode == OP_SW):    next = MEMADR;
               (opcode == OP_RTYPE): next = EXECUTE;
               (opcode == OP_ADDI):  next = ADDIEX;
               (opcode == OP_BEQ),
               (opcode == OP_BNE):   next = BRANCH;
               (opcode == OP_J):     next = JUMP;
               default: begin
                  illegal = 1'b1;
                  next    = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            next    = (op_q == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            if (mem_ready)
               next = MEMWB;
            else if (expire)
               next = ERROR;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            next     = FETCH;
            retire   = 1'b1;
         end
         MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               next   = FETCH;
               retire = 1'b1;
            end else if (expire) begin
               next = ERROR;
            end
         end
         EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALU_FUNCT;
            next    = ALUWB;
         end
         ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            next     = FETCH;
            retire   = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            next    = ADDIWB;
         end
         ADDIWB: begin
            regwrite = 1'b1;
            next     = FETCH;
            retire   = 1'b1;
         end
         BRANCH: begin
            alusrca    = 1'b1;
            aluop      = ALU_SUB;
            pcsource   = PC_ALUOUT;
            pcwrite_eq = (op_q == OP_BEQ);
            pcwrite_ne = (op_q == OP_BNE);
            next       = FETCH;
            retire     = 1'b1;
         end
         JUMP: begin
            pcwrite  = 1'b1;
            pcsource = PC_JUMP;
            next     = FETCH;
            retire   = 1'b1;
         end
         ERROR: error = 1'b1;
         default: next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: walks each instruction class through the
// FSM and compares every control output cycle by cycle.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pcwrite, pcwrite_eq, pcwrite_ne, iord;
   logic        memread, memwrite, irwrite, memtoreg;
   logic        regdst, regwrite, alusrca, illegal, error;
   logic [1:0]  alusrcb, aluop, pcsource;
   logic [31:0] instr_count;

   int n_chk  = 0;
   int n_fail = 0;

   multicycle_control #(
      .WAIT_MAX(4),
      .CNT_W   (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .pcwrite    (pcwrite),
      .pcwrite_eq (pcwrite_eq),
      .pcwrite_ne (pcwrite_ne),
      .iord       (iord),
      .memread    (memread),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .aluop      (aluop),
      .pcsource   (pcsource),
      .illegal    (illegal),
      .error      (error),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Control vector, MSB first:
   // pcw eq ne iord mr mw irw m2r rdst rw asa asb[2] aop[2] psrc[2] ill err
   logic [18:0] ctl;
   assign ctl = {pcwrite, pcwrite_eq, pcwrite_ne, iord, memread,
                 memwrite, irwrite, memtoreg, regdst, regwrite,
                 alusrca, alusrcb, aluop, pcsource, illegal, error};

   localparam logic [18:0] C_IDLE   = 19'b0000000000_0_00_00_00_0_0;
   localparam logic [18:0] C_FET0   = 19'b0000100000_0_01_00_00_0_0;
   localparam logic [18:0] C_FET1   = 19'b1000101000_0_01_00_00_0_0;
   localparam logic [18:0] C_DEC    = 19'b0000000000_0_11_00_00_0_0;
   localparam logic [18:0] C_DECILL = 19'b0000000000_0_11_00_00_1_0;
   localparam logic [18:0] C_MADR   = 19'b0000000000_1_10_00_00_0_0;
   localparam logic [18:0] C_MRD    = 19'b0001100000_0_00_00_00_0_0;
   localparam logic [18:0] C_MWB    = 19'b0000000101_0_00_00_00_0_0;
   localparam logic [18:0] C_MWR    = 19'b0001010000_0_00_00_00_0_0;
   localparam logic [18:0] C_EXE    = 19'b0000000000_1_00_10_00_0_0;
   localparam logic [18:0] C_AWB    = 19'b0000000011_0_00_00_00_0_0;
   localparam logic [18:0] C_IEX    = 19'b0000000000_1_10_00_00_0_0;
   localparam logic [18:0] C_IWB    = 19'b0000000001_0_00_00_00_0_0;
   localparam logic [18:0] C_BEQ    = 19'b0100000000_1_00_01_01_0_0;
   localparam logic [18:0] C_BNE    = 19'b0010000000_1_00_01_01_0_0;
   localparam logic [18:0] C_JMP    = 19'b1000000000_0_00_00_10_0_0;
   localparam logic [18:0] C_ERR    = 19'b0000000000_0_00_00_00_0_1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive mem_ready, compare controls for this cycle, then clock.
   task automatic cyc(input string tag, input logic rdy,
                      input logic [18:0] exp);
      mem_ready = rdy;
      #1;
      check(tag, {13'd0, ctl}, {13'd0, exp});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      mem_ready = 1'b0;
      opcode    = 6'b000000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctl", {13'd0, ctl}, {13'd0, C_IDLE});
      check("reset_cnt", instr_count, 32'd0);
      rst = 1'b0;

      opcode = 6'b100011;
      cyc("lw_idle", 1'b1, C_IDLE);
      cyc("lw_fetch", 1'b1, C_FET1);
      cyc("lw_dec", 1'b1, C_DEC);
      cyc("lw_madr", 1'b1, C_MADR);
      cyc("lw_mrd", 1'b1, C_MRD);
      cyc("lw_mwb", 1'b1, C_MWB);
      check("lw_cnt", instr_count, 32'd1);

      opcode = 6'b000100;
      cyc("beq_fetch", 1'b1, C_FET1);
      cyc("beq_dec", 1'b1, C_DEC);
      cyc("beq_br", 1'b1, C_BEQ);
      check("beq_cnt", instr_count, 32'd2);

      opcode = 6'b000101;
      cyc("bne_fetch", 1'b1, C_FET1);
      cyc("bne_dec", 1'b1, C_DEC);
      cyc("bne_br", 1'b1, C_BNE);
      check("bne_cnt", instr_count, 32'd3);

      opcode = 6'b101011;
      cyc("sw_fetch", 1'b1, C_FET1);
      cyc("sw_dec", 1'b1, C_DEC);
      cyc("sw_madr", 1'b1, C_MADR);
      for (int i = 0; i < 3; i++) begin
         cyc("sw_wait", 1'b0, C_MWR);
         check("sw_wait_cnt", instr_count, 32'd3);
      end
      cyc("sw_done", 1'b1, C_MWR);
      check("sw_cnt", instr_count, 32'd4);

      opcode = 6'b111111;
      cyc("ill_fetch", 1'b1, C_FET1);
      cyc("ill_dec", 1'b1, C_DECILL);
      check("ill_cnt", instr_count, 32'd4);
      cyc("ill_refetch", 1'b0, C_FET0);

      for (int i = 0; i < 4; i++)
         cyc("to_fetch", 1'b0, C_FET0);
      cyc("to_err1", 1'b0, C_ERR);
      cyc("to_err2", 1'b1, C_ERR);
      cyc("to_err3", 1'b1, C_ERR);
      check("to_cnt", instr_count, 32'd4);

      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_err", {31'd0, error}, 32'd0);
      check("rst_cnt", instr_count, 32'd0);

      opcode = 6'b100011;
      cyc("mid_idle", 1'b1, C_IDLE);
      cyc("mid_fetch", 1'b1, C_FET1);
      cyc("mid_dec", 1'b1, C_DEC);
      cyc("mid_madr", 1'b1, C_MADR);
      cyc("mid_mrd1", 1'b0, C_MRD);
      cyc("mid_mrd2", 1'b0, C_MRD);
      rst = 1'b1;
      cyc("mid_mrd3", 1'b0, C_MRD);
      rst = 1'b0;
      check("mid_memread", {31'd0, memread}, 32'd0);
      check("mid_cnt", instr_count, 32'd0);
      cyc("mid_idle2", 1'b1, C_IDLE);

      opcode = 6'b000010;
      cyc("j_fetch", 1'b1, C_FET1);
      cyc("j_dec", 1'b1, C_DEC);
      cyc("j_jump", 1'b1, C_JMP);
      check("j_cnt", instr_count, 32'd1);

      opcode = 6'b000000;
      cyc("r_fetch", 1'b1, C_FET1);
      cyc("r_dec", 1'b1, C_DEC);
      cyc("r_exe", 1'b1, C_EXE);
      cyc("r_awb", 1'b1, C_AWB);
      check("r_cnt", instr_count, 32'd2);

      opcode = 6'b001000;
      cyc("addi_fetch", 1'b1, C_FET1);
      cyc("addi_dec", 1'b1, C_DEC);
      cyc("addi_ex", 1'b1, C_IEX);
      cyc("addi_wb", 1'b1, C_IWB);
      check("addi_cnt", instr_count, 32'd3);
      cyc("addi_next", 1'b0, C_FET0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style FSM that sequences the multi-cycle MIPS datapath: a shared ALU, a unified instruction/data memory, the IR, the PC, and the register file. It replaces the single-cycle opcode decoder in the multi-cycle CPU variant. It supports lw, sw, R-type (opcode 000000), addi, beq, bne and j. It adds a memory ready handshake with a wait timeout and a counter of retired instructions.

Parameters:
WAIT_MAX, 15, maximum consecutive cycles mem_ready may stay low in a memory state before entering ERROR; 0 disables the timeout.
CNT_W, 32, width of instr_count.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
opcode  in  6  IR[31:26]; valid from DECODE onward.
mem_ready  in  1  memory completes the current read or write this cycle.
pcwrite  out  1  unconditional PC load.
pcwrite_eq  out  1  PC load if ALU zero (beq).
pcwrite_ne  out  1  PC load if ALU not zero (bne).
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
memread  out  1  memory read request.
memwrite  out  1  memory write request.
irwrite  out  1  IR load.
memtoreg  out  1  register write-back data select: 1 = MDR, 0 = ALUOut.
regdst  out  1  destination register select: 1 = rd, 0 = rt.
regwrite  out  1  register file write enable.
alusrca  out  1  ALU operand A select: 0 = PC, 1 = A.
alusrcb  out  2  ALU operand B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
aluop  out  2  00 = add, 01 = sub, 10 = decode funct.
pcsource  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
illegal  out  1  one-cycle pulse on an unknown opcode.
error  out  1  sticky timeout flag.
instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ERROR.
- Any control output not listed for a state is 0.
- Reset (rst high at a clock edge, from any state, including mid-wait):
  - state becomes IDLE.
  - instr_count, wait counter and op_q become 0.
  - error is 0.
  - All outputs are 0 while in IDLE.
- IDLE: all outputs 0; next state is FETCH.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite follow mem_ready (the only Mealy terms).
  - Stay while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00; the branch target goes into ALUOut.
  - opcode is latched into op_q.
  - Next state by opcode:
    - 100011 or 101011 → MEMADR.
    - 000000 → EXECUTE.
    - 001000 → ADDIEX.
    - 000100 or 000101 → BRANCH.
    - 000010 → JUMP.
    - Any other opcode → FETCH, with illegal=1 for this cycle and no retire.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state is MEMRD if op_q is lw, else MEMWR.
- MEMRD: memread=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Go to FETCH; retire.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready=1, then go to FETCH; retire.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH; retire.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH; retire.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01.
  - pcwrite_eq=1 if op_q is beq; pcwrite_ne=1 if op_q is bne.
  - Go to FETCH; retire.
- JUMP: pcwrite=1, pcsource=10. Go to FETCH; retire.
- Retire: instr_count increments by 1 on the clock edge that leaves a retiring state toward FETCH. It wraps modulo 2^CNT_W.
- Timeout (WAIT_MAX > 0):
  - The wait counter increments each cycle in FETCH, MEMRD or MEMWR with mem_ready=0.
  - It clears on mem_ready=1 and on any state change.
  - If the counter equals WAIT_MAX and mem_ready=0, the next state is ERROR.
- ERROR: all control outputs 0, error=1. Exit only by reset.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each memory wait cycle adds 1.

Decomposition:
- Shared package or include (mips_defs): opcode constants, aluop encodings, alusrcb encodings, pcsource encodings, state encoding localparams.
- No sub-module. If reuse is wanted, the timeout counter may be split out as wait_timer.

Test Plan:
- Reset then lw (100011), mem_ready always 1 → sequence IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 on cycle 6; instr_count=1.
- beq (000100) → pcwrite_eq=1, aluop=01, pcsource=01 on the 3rd cycle after FETCH entry; pcwrite_ne=0. Repeat with bne (000101) → pcwrite_ne=1, pcwrite_eq=0.
- sw with mem_ready held low 3 cycles in MEMWR → memwrite stays 1 for 4 cycles; exit on mem_ready; 7 cycles total; instr_count increments once.
- Opcode 111111 → illegal pulses for 1 cycle in DECODE; next state FETCH; instr_count unchanged.
- WAIT_MAX=4 with mem_ready stuck 0 in FETCH → ERROR after 5 cycles; error=1 and all controls 0 until rst; rst → IDLE with error=0.
- rst asserted mid-MEMRD → IDLE next cycle; memread=0; instr_count=0. Then j (000010) runs in 3 cycles with pcsource=10.
